// File: rtl/dcache_wb.sv
// dcache_wb - write-back, write-allocate data cache with a single outstanding
// CPU request. Lines are LINE_WORDS 32-bit words, NUM_WAYS-way set associative
// with per-set round-robin replacement among valid ways.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            CPU request handshake (ready only when idle)
//   write_en, req_addr, write_data CPU store/load, byte address, store data
//   size, sign                     access width (B/H/W) and load sign-extend
//   resp_valid/resp_data/resp_err  one-cycle response, load data, misalignment
//   mem_rd_*                       line fill: request/grant, then data beats
//   mem_wr_*                       write-back beats with ready backpressure
//   hit_cnt/miss_cnt/wb_cnt        statistics, only with DCACHE_WB_STATS_EN
//
// Build option: define DCACHE_WB_STATS_EN to add saturating hit/miss/write-back
// counters and their output ports.

package dcache_wb_pkg;
    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2
    } mem_read_size_t;
endpackage

module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int NUM_WAYS   = 2,
    parameter int NUM_SETS   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           write_en,
    input  logic [31:0]    req_addr,
    input  logic [31:0]    write_data,
    input  mem_read_size_t size,
    input  logic           sign,
    output logic           resp_valid,
    output logic [31:0]    resp_data,
    output logic           resp_err,
    output logic           mem_rd_req,
    output logic [31:0]    mem_rd_addr,
    input  logic           mem_rd_gnt,
    input  logic           mem_rd_dvalid,
    input  logic [31:0]    mem_rd_data,
    output logic           mem_wr_req,
    output logic [31:0]    mem_wr_addr,
    output logic [31:0]    mem_wr_data,
    input  logic           mem_wr_ready
`ifdef DCACHE_WB_STATS_EN
    ,
    output logic [31:0]    hit_cnt,
    output logic [31:0]    miss_cnt,
    output logic [31:0]    wb_cnt
`endif
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);
    localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WB     = 3'd2,
        FILL   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t state;

    // registered request
    logic [TAG_W-1:0]  r_tag;
    logic [IDX_W-1:0]  r_set;
    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_boff;
    logic              r_write;
    logic [31:0]       r_wdata;
    mem_read_size_t    r_size;
    logic              r_sign;
    logic              r_err;

    logic [WAY_W-1:0]  r_way;
    logic [WORD_W-1:0] beat;
    logic [WORD_W-1:0] beat_nxt;
    logic              granted;

    // line state
    logic [NUM_WAYS-1:0] valid [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty [NUM_SETS];
    logic [WAY_W-1:0]    rr    [NUM_SETS];
    logic [TAG_W-1:0]    tag_mem  [NUM_WAYS][NUM_SETS];
    logic [31:0]         data_mem [NUM_WAYS][NUM_SETS][LINE_WORDS];

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              found_inv;
    logic [WAY_W-1:0]  victim;
    logic              victim_dirty;
    logic              misaligned;
    logic [31:0]       line_addr;

    logic              dm_we;
    logic [WAY_W-1:0]  dm_way;
    logic [WORD_W-1:0] dm_word;
    logic [31:0]       dm_wdata;
    logic              tag_we;

    function automatic logic [31:0] merge_store(input logic [31:0]    old,
                                                input logic [31:0]    wd,
                                                input mem_read_size_t sz,
                                                input logic [1:0]     boff);
        logic [31:0] res;
        res = old;
        case (sz)
            MEM_SIZE_B: res[{boff, 3'b000} +: 8]        = wd[7:0];
            MEM_SIZE_H: res[{boff[1], 4'b0000} +: 16]   = wd[15:0];
            default:    res                             = wd;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0]    word,
                                                input mem_read_size_t sz,
                                                input logic           sgn,
                                                input logic [1:0]     boff);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {boff, 3'b000};
        case (sz)
            MEM_SIZE_B: res = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
            MEM_SIZE_H: res = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            default:    res = word;
        endcase
        return res;
    endfunction

    assign req_ready = (state == IDLE);
    assign beat_nxt  = beat + WORD_W'(1);
    assign line_addr = {r_tag, r_set, {OFF_W{1'b0}}};

    always_comb begin
        misaligned = 1'b0;
        case (size)
            MEM_SIZE_B: misaligned = 1'b0;
            MEM_SIZE_H: misaligned = req_addr[0];
            default:    misaligned = (req_addr[1:0] != 2'b00);
        endcase
    end

    // Tag compare and victim choice: lowest-index invalid way wins, otherwise
    // the set's round-robin pointer.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        victim    = rr[r_set];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[r_set][w] && (tag_mem[w][r_set] == r_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid[r_set][w] && !found_inv) begin
                found_inv = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        victim_dirty = valid[r_set][victim] && dirty[r_set][victim];
    end

    // Data array write port. A pending store is merged into its fill beat on
    // the fly so the store and the refill never collide on the same word.
    always_comb begin
        dm_we    = 1'b0;
        dm_way   = r_way;
        dm_word  = beat;
        dm_wdata = mem_rd_data;
        tag_we   = 1'b0;
        if (state == LOOKUP && !r_err && hit && r_write) begin
            dm_we    = 1'b1;
            dm_way   = hit_way;
            dm_word  = r_word;
            dm_wdata = merge_store(data_mem[hit_way][r_set][r_word], r_wdata, r_size, r_boff);
        end else if (state == FILL && granted && mem_rd_dvalid) begin
            dm_we    = 1'b1;
            dm_way   = r_way;
            dm_word  = beat;
            dm_wdata = (r_write && beat == r_word)
                       ? merge_store(mem_rd_data, r_wdata, r_size, r_boff)
                       : mem_rd_data;
            tag_we   = (beat == LAST_BEAT);
        end
    end

    always_ff @(posedge clk) begin
        if (dm_we)
            data_mem[dm_way][r_set][dm_word] <= dm_wdata;
        if (tag_we)
            tag_mem[r_way][r_set] <= r_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r_tag       <= '0;
            r_set       <= '0;
            r_word      <= '0;
            r_boff      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_size      <= MEM_SIZE_B;
            r_sign      <= 1'b0;
            r_err       <= 1'b0;
            r_way       <= '0;
            beat        <= '0;
            granted     <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                rr[s]    <= '0;
            end
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_tag   <= req_addr[31 -: TAG_W];
                        r_set   <= req_addr[OFF_W +: IDX_W];
                        r_word  <= req_addr[2 +: WORD_W];
                        r_boff  <= req_addr[1:0];
                        r_write <= write_en;
                        r_wdata <= write_data;
                        r_size  <= size;
                        r_sign  <= sign;
                        r_err   <= misaligned;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (r_err) begin
                        state <= RESP;
                    end else if (hit) begin
                        r_way <= hit_way;
                        if (r_write)
                            dirty[r_set][hit_way] <= 1'b1;
                        state <= RESP;
                    end else begin
                        r_way   <= victim;
                        beat    <= '0;
                        granted <= 1'b0;
                        valid[r_set][victim] <= 1'b0;
                        if (!found_inv)
                            rr[r_set] <= (rr[r_set] == LAST_WAY) ? '0 : rr[r_set] + WAY_W'(1);
                        if (victim_dirty) begin
                            mem_wr_req  <= 1'b1;
                            mem_wr_addr <= {tag_mem[victim][r_set], r_set, {OFF_W{1'b0}}};
                            mem_wr_data <= data_mem[victim][r_set][0];
                            state       <= WB;
                        end else begin
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= line_addr;
                            state       <= FILL;
                        end
                    end
                end
                WB: begin
                    if (mem_wr_ready) begin
                        if (beat == LAST_BEAT) begin
                            mem_wr_req  <= 1'b0;
                            mem_wr_addr <= '0;
                            mem_wr_data <= '0;
                            beat        <= '0;
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= line_addr;
                            state       <= FILL;
                        end else begin
                            beat        <= beat_nxt;
                            mem_wr_data <= data_mem[r_way][r_set][beat_nxt];
                        end
                    end
                end
                FILL: begin
                    if (!granted) begin
                        if (mem_rd_gnt) begin
                            granted    <= 1'b1;
                            mem_rd_req <= 1'b0;
                        end
                    end else if (mem_rd_dvalid) begin
                        if (beat == LAST_BEAT) begin
                            valid[r_set][r_way] <= 1'b1;
                            dirty[r_set][r_way] <= r_write;
                            mem_rd_addr <= '0;
                            granted     <= 1'b0;
                            beat        <= '0;
                            state       <= RESP;
                        end else begin
                            beat <= beat_nxt;
                        end
                    end
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= r_err;
                    resp_data  <= (r_err || r_write)
                                  ? 32'h0
                                  : extend_load(data_mem[r_way][r_set][r_word], r_size, r_sign, r_boff);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_WB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else if (state == LOOKUP && !r_err) begin
            if (hit) begin
                if (hit_cnt != 32'hFFFF_FFFF)
                    hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF)
                    miss_cnt <= miss_cnt + 32'd1;
                if (victim_dirty && wb_cnt != 32'hFFFF_FFFF)
                    wb_cnt <= wb_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
